data_memory_lanes: RTL and testbench

//  Parametrised data memory for the RV32 single-cycle core, the successor to the fixed 32x32 data store.

---
 rtl/data_memory_lanes.sv | 176 +++++++++++++++++
 tb/tb_data_memory_lanes.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/data_memory_lanes.sv
// data_memory_lanes
//   Byte-addressable data memory for the RV32 single-cycle core. It supports
//   byte, half-word and word access, with sign or zero extension on loads. It
//   flags misaligned and out-of-range accesses. After every reset a clear
//   engine walks the whole array and writes INIT_VALUE into each word.
//
//   Parameters
//     DEPTH       number of 32-bit words (power of 2, >= 4)
//     INIT_VALUE  value written into every word by the clear engine
//
//   Ports
//     CLK        clock; all state updates happen on posedge
//     RST        synchronous reset, active-high
//     WE / RE    store / load request
//     FUNCT3     RV32 width code (B, H, W, BU, HU)
//     A_DM       byte address
//     WD         store data, right-aligned
//     RD3        load data, extended, combinational
//     BUSY       high while the clear engine is running
//     MISALIGN   combinational misaligned-access flag
//     FAULT      sticky fault flag      (only with DM_FAULT_LATCH_EN)
//     FAULT_ADDR first faulting address (only with DM_FAULT_LATCH_EN)
//
//   Optional feature macro: DM_FAULT_LATCH_EN
module data_memory_lanes #(
  parameter int          DEPTH      = 256,
  parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        WE,
  input  logic        RE,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] A_DM,
  input  logic [31:0] WD,
  output logic [31:0] RD3,
  output logic        BUSY,
  output logic        MISALIGN
`ifdef DM_FAULT_LATCH_EN
  ,
  output logic        FAULT,
  output logic [31:0] FAULT_ADDR
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   mem_q [DEPTH];

  logic          ready;
  logic          clr_we;
  logic          sz_b, sz_h, sz_w, valid_code;
  logic          in_range, misal_raw;
  logic [AW-1:0] word_idx;
  logic          st_we;
  logic [3:0]    be;
  logic [31:0]   wlanes;
  logic [31:0]   rd_word;

  function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                              input logic [31:0] word,
                                              input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  load_extend = {{24{b[7]}}, b};
      3'b100:  load_extend = {24'h0, b};
      3'b001:  load_extend = {{16{h[15]}}, h};
      3'b101:  load_extend = {16'h0, h};
      3'b010:  load_extend = word;
      default: load_extend = 32'h0;
    endcase
  endfunction

  // Width decode. The BU/HU codes share their width with B/H.
  assign sz_b       = (FUNCT3[1:0] == 2'b00);
  assign sz_h       = (FUNCT3[1:0] == 2'b01);
  assign sz_w       = (FUNCT3 == 3'b010);
  assign valid_code = sz_b | sz_h | sz_w;

  assign ready     = (state_q == ST_READY);
  assign in_range  = ((A_DM >> (AW + 2)) == 32'd0);
  assign misal_raw = (sz_h & A_DM[0]) | (sz_w & (A_DM[1:0] != 2'b00));
  assign word_idx  = A_DM[AW+1:2];

  assign BUSY     = ~ready;
  assign MISALIGN = ready & (WE | RE) & misal_raw;

  // Clear engine: one word per cycle, then READY after the last word.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    clr_we  = 1'b0;
    if (state_q == ST_CLEAR) begin
      clr_we = ~RST;
      idx_d  = idx_q + 1'b1;
      if (idx_q == AW'(DEPTH - 1)) state_d = ST_READY;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Store path: the data is replicated across lanes and the byte enables pick the target.
  always_comb begin
    st_we  = ready & ~RST & WE & in_range & ~misal_raw & valid_code;
    be     = 4'b0000;
    wlanes = WD;
    if (sz_b) begin
      be     = 4'b0001 << A_DM[1:0];
      wlanes = {4{WD[7:0]}};
    end else if (sz_h) begin
      be     = A_DM[1] ? 4'b1100 : 4'b0011;
      wlanes = {2{WD[15:0]}};
    end else if (sz_w) begin
      be     = 4'b1111;
    end
  end

  always_ff @(posedge CLK) begin
    if (clr_we) begin
      mem_q[idx_q] <= INIT_VALUE;
    end else if (st_we) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) mem_q[word_idx][8*l +: 8] <= wlanes[8*l +: 8];
      end
    end
  end

  // Asynchronous read, so a same-cycle store is seen only after the edge.
  assign rd_word = mem_q[word_idx];
  assign RD3     = (ready & in_range & ~misal_raw & valid_code)
                 ? load_extend(FUNCT3, rd_word, A_DM[1:0]) : 32'h0;

`ifdef DM_FAULT_LATCH_EN
  logic        fault_q, fault_d;
  logic [31:0] fault_addr_q, fault_addr_d;

  // Only the first faulting access is recorded. Later ones are ignored until reset.
  always_comb begin
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    if (ready & (WE | RE) & (misal_raw | ~in_range) & ~fault_q) begin
      fault_d      = 1'b1;
      fault_addr_d = A_DM;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fault_q      <= 1'b0;
      fault_addr_q <= 32'h0;
    end else begin
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign FAULT      = fault_q;
  assign FAULT_ADDR = fault_addr_q;
`endif

endmodule

// File: tb/tb_data_memory_lanes.sv
module tb_data_memory_lanes;

  localparam int          DEPTH = 256;
  localparam int          NBYTE = DEPTH * 4;
  localparam logic [31:0] INIT  = 32'h0000_000A;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        WE = 1'b0, RE = 1'b0;
  logic [2:0]  FUNCT3 = 3'b010;
  logic [31:0] A_DM = 32'h0, WD = 32'h0;
  logic [31:0] RD3;
  logic        BUSY, MISALIGN;
`ifdef DM_FAULT_LATCH_EN
  logic        FAULT;
  logic [31:0] FAULT_ADDR;
  logic        fault_exp;
  logic [31:0] fault_addr_exp;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mm [NBYTE];

  always #5 CLK = ~CLK;

  data_memory_lanes #(.DEPTH(DEPTH), .INIT_VALUE(INIT)) dut (
    .CLK(CLK), .RST(RST), .WE(WE), .RE(RE), .FUNCT3(FUNCT3), .A_DM(A_DM),
    .WD(WD), .RD3(RD3), .BUSY(BUSY), .MISALIGN(MISALIGN)
`ifdef DM_FAULT_LATCH_EN
    , .FAULT(FAULT), .FAULT_ADDR(FAULT_ADDR)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int op_size(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit op_mis(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = op_size(f3);
    return (sz == 2 && (a % 2) != 0) || (sz == 4 && (a % 4) != 0);
  endfunction

  function automatic bit in_rng(input logic [31:0] a);
    return a < 32'(NBYTE);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int sz;
    sz = op_size(f3);
    if (sz == 0 || !in_rng(a) || op_mis(f3, a)) return 32'h0;
    v = 32'h0;
    for (int k = 0; k < sz; k++) v = v | (32'(mm[int'(a) + k]) << (8 * k));
    if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
    if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NBYTE; i++) mm[i] = INIT[8*(i%4) +: 8];
  endtask

  // One access in READY: check the combinational outputs before the edge, then apply it to the model.
  task automatic do_op(input logic we, input logic re, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input string tag);
    bit mis;
    int sz;
    mis = op_mis(f3, a);
    sz  = op_size(f3);
    WE = we; RE = re; FUNCT3 = f3; A_DM = a; WD = wd;
    #1;
    check({tag, "_mis"}, {31'b0, MISALIGN}, {31'b0, (we | re) & mis});
    check({tag, "_rd"}, RD3, model_load(f3, a));
`ifdef DM_FAULT_LATCH_EN
    if ((we | re) && (mis || !in_rng(a)) && !fault_exp) begin
      fault_exp = 1'b1;
      fault_addr_exp = a;
    end
`endif
    @(posedge CLK); #1;
    if (we && sz > 0 && !mis && in_rng(a))
      for (int k = 0; k < sz; k++) mm[int'(a) + k] = wd[8*k +: 8];
    WE = 1'b0; RE = 1'b0;
`ifdef DM_FAULT_LATCH_EN
    check({tag, "_fault"}, {31'b0, FAULT}, {31'b0, fault_exp});
    check({tag, "_faddr"}, FAULT_ADDR, fault_addr_exp);
`endif
  endtask

  task automatic expect_load(input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] exp, input string tag);
    WE = 1'b0; RE = 1'b1; FUNCT3 = f3; A_DM = a;
    #1;
    check(tag, RD3, exp);
    @(posedge CLK); #1;
    RE = 1'b0;
  endtask

  // Reset for two cycles, then count BUSY cycles while hammering the DUT with accesses.
  // If pulse_at >= 0, reset is pulsed again at that clear cycle and the count restarts.
  task automatic run_clear(input int pulse_at);
    int cnt;
    int pa;
    pa = pulse_at;
    RST = 1'b1;
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;
    check("rst_busy", {31'b0, BUSY}, 32'd1);
`ifdef DM_FAULT_LATCH_EN
    fault_exp = 1'b0; fault_addr_exp = 32'h0;
    check("rst_fault", {31'b0, FAULT}, 32'd0);
    check("rst_faddr", FAULT_ADDR, 32'h0);
`endif
    cnt = 0;
    while (BUSY === 1'b1 && cnt <= DEPTH + 4) begin
      if (cnt == pa) begin
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        cnt = 0;
        pa = -1;
      end
      WE = 1'b1; RE = 1'b1; FUNCT3 = 3'($urandom_range(0, 7));
      A_DM = 32'($urandom_range(0, NBYTE - 1)); WD = $urandom;
      #1;
      check("busy_rd", RD3, 32'h0);
      check("busy_mis", {31'b0, MISALIGN}, 32'd0);
      @(posedge CLK); #1;
      cnt++;
    end
    WE = 1'b0; RE = 1'b0;
    check("busy_cycles", 32'(cnt), 32'(DEPTH));
    model_clear();
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    @(posedge CLK); #1;

    run_clear(-1);
    expect_load(3'd2, 32'h3FC, 32'h0000_000A, "init_lw_3fc");

    do_op(1'b1, 1'b0, 3'd2, 32'h10, 32'h8000_00FF, "sw_10");
    do_op(1'b1, 1'b0, 3'd0, 32'h11, 32'h0000_0012, "sb_11");
    expect_load(3'd2, 32'h10, 32'h8000_12FF, "lw_10");
    expect_load(3'd0, 32'h10, 32'hFFFF_FFFF, "lb_10");
    expect_load(3'd4, 32'h10, 32'h0000_00FF, "lbu_10");
    expect_load(3'd1, 32'h12, 32'hFFFF_8000, "lh_12");

    do_op(1'b1, 1'b0, 3'd1, 32'h13, 32'h0000_5555, "sh_13");
    expect_load(3'd2, 32'h10, 32'h8000_12FF, "lw_10_after_sh");
    do_op(1'b0, 1'b1, 3'd2, 32'h12, 32'h0, "lw_12");
`ifdef DM_FAULT_LATCH_EN
    check("fault_first", {31'b0, FAULT}, 32'd1);
    check("faddr_first", FAULT_ADDR, 32'h13);
`endif

    do_op(1'b1, 1'b0, 3'd2, 32'h400, 32'h1234, "sw_400");
    expect_load(3'd2, 32'h0, 32'h0000_000A, "lw_0_unchanged");
    do_op(1'b0, 1'b1, 3'd2, 32'h400, 32'h0, "lw_400");

    do_op(1'b1, 1'b1, 3'd2, 32'h20, 32'hDEAD_BEEF, "sw_lw_20");
    expect_load(3'd2, 32'h20, 32'hDEAD_BEEF, "lw_20_next");

    for (int i = 0; i < 400; i++) begin
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) a = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(NBYTE, NBYTE + 64));
      else a = 32'($urandom_range(0, NBYTE - 1));
      do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), f3, a, $urandom, "rand");
    end

    run_clear(100);
    for (int i = 0; i < 20; i++) begin
      do_op(1'b0, 1'b1, 3'd2, 32'($urandom_range(0, DEPTH - 1)) << 2, 32'h0, "post_clear");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
